// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan driver.
package keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } kp_state_t;

  // Column index of a one-hot return; 0 for anything not one-hot.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops to settle metastability.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: rotates a one-hot row drive, freezes on a
// one-hot column return, debounces press and release, and emits one
// encoded key event per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 27000,
  parameter int unsigned DEBOUNCE = 270000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

  logic [3:0]       cs;
  kp_state_t        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       filas_q, filas_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;

  logic div_done, deb_done, cs_match, cs_zero;

  sync2 #(
    .WIDTH(4)
  ) u_sync (
    .clk    (clk),
    .n_reset(n_reset),
    .d      (columnas),
    .q      (cs)
  );

  assign div_done = (div_q == DIV_LAST);
  assign deb_done = (deb_q == DEB_LAST);
  assign cs_match = (cs == pat_q);
  assign cs_zero  = (cs == 4'd0);

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= SCAN;
    else          state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCAN:    if (div_done && is_onehot(cs)) state_d = CONFIRM;
      CONFIRM: begin
        if (!cs_match)    state_d = SCAN;
        else if (deb_done) state_d = HELD;
      end
      HELD:    if (cs_zero && deb_done) state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  // Counters, row drive and key outputs for the next cycle.
  always_comb begin
    div_d   = div_q;
    deb_d   = deb_q;
    row_d   = row_q;
    col_d   = col_q;
    filas_d = filas_q;
    pat_d   = pat_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    unique case (state_q)
      SCAN: begin
        if (div_done) begin
          div_d = '0;
          if (is_onehot(cs)) begin
            // Row stays put so the confirm phase sees the same key.
            col_d = onehot_to_idx(cs);
            pat_d = cs;
            deb_d = '0;
          end else begin
            row_d   = row_q + 2'd1;
            filas_d = {filas_q[2:0], filas_q[3]};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      CONFIRM: begin
        if (!cs_match) begin
          div_d = '0;
        end else if (deb_done) begin
          code_d  = {row_q, col_q};
          valid_d = 1'b1;
          held_d  = 1'b1;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      HELD: begin
        // Any activity, including a second key, restarts the release count.
        if (!cs_zero) begin
          deb_d = '0;
        end else if (deb_done) begin
          held_d  = 1'b0;
          row_d   = row_q + 2'd1;
          filas_d = {filas_q[2:0], filas_q[3]};
          div_d   = '0;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      div_q   <= '0;
      deb_q   <= '0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      filas_q <= 4'b0001;
      pat_q   <= 4'd0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      deb_q   <= deb_d;
      row_q   <= row_d;
      col_q   <= col_d;
      filas_q <= filas_d;
      pat_q   <= pat_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign filas     = filas_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE=4.
module tb_keypad_scanner;

  logic       clk;
  logic       n_reset;
  logic [3:0] columnas;
  logic [3:0] filas;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int checks;
  int errors;
  int vcount;

  keypad_scanner #(
    .SCAN_DIV(8),
    .DEBOUNCE(4)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .columnas (columnas),
    .filas    (filas),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count key_valid pulses seen at each rising edge.
  always @(posedge clk) begin
    if (key_valid === 1'b1) vcount <= vcount + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    vcount   = 0;
    n_reset  = 1'b0;
    columnas = 4'd0;
    #12 n_reset = 1'b1;

    // Asynchronous reset mid-operation.
    tick(20);
    #3 n_reset = 1'b0;
    #1;
    check("rst_filas", 8'(filas), 8'h01);
    check("rst_code", 8'(key_code), 8'h00);
    check("rst_valid", 8'(key_valid), 8'h00);
    check("rst_held", 8'(key_held), 8'h00);
    tick(1);
    n_reset = 1'b1;

    // Idle rotation, 8 cycles per row.
    tick(7); check("rot_r0_dwell", 8'(filas), 8'h01);
    tick(1); check("rot_r1", 8'(filas), 8'h02);
    tick(8); check("rot_r2", 8'(filas), 8'h04);
    tick(8); check("rot_r3", 8'(filas), 8'h08);
    tick(8); check("rot_wrap", 8'(filas), 8'h01);

    // Single press on row 2, column 1.
    tick(16); check("sp_row2", 8'(filas), 8'h04);
    columnas = 4'b0010;
    tick(11);
    check("sp_pre_valid", 8'(key_valid), 8'h00);
    check("sp_pre_held", 8'(key_held), 8'h00);
    tick(1);
    check("sp_valid", 8'(key_valid), 8'h01);
    check("sp_code", 8'(key_code), 8'h09);
    check("sp_held", 8'(key_held), 8'h01);
    check("sp_frozen", 8'(filas), 8'h04);
    tick(1);
    check("sp_pulse_end", 8'(key_valid), 8'h00);
    columnas = 4'b0000;
    tick(5); check("sp_rel_early", 8'(key_held), 8'h01);
    tick(1);
    check("sp_rel_held", 8'(key_held), 8'h00);
    check("sp_rel_filas", 8'(filas), 8'h08);
    check("sp_vcount", 8'(vcount), 8'd1);

    // Bounce on row 0: one aborted confirm, no event, scan moves on.
    tick(8); check("bn_row0", 8'(filas), 8'h01);
    for (int p = 0; p < 4; p++) begin
      columnas = 4'b0001;
      tick(2);
      columnas = 4'b0000;
      tick(2);
    end
    check("bn_still_row0", 8'(filas), 8'h01);
    tick(1);
    check("bn_advance", 8'(filas), 8'h02);
    check("bn_vcount", 8'(vcount), 8'd1);

    // Six-cycle stable press on row 0, column 0.
    tick(24); check("bn_back_row0", 8'(filas), 8'h01);
    tick(4);
    columnas = 4'b0001;
    tick(6);
    columnas = 4'b0000;
    tick(1); check("st_pre_valid", 8'(key_valid), 8'h00);
    tick(1);
    check("st_valid", 8'(key_valid), 8'h01);
    check("st_code", 8'(key_code), 8'h00);
    check("st_held", 8'(key_held), 8'h01);
    tick(4);
    check("st_rel_held", 8'(key_held), 8'h00);
    check("st_rel_filas", 8'(filas), 8'h02);
    check("st_vcount", 8'(vcount), 8'd2);

    // Two columns on row 1 are ignored.
    columnas = 4'b0011;
    tick(7); check("mc_dwell", 8'(filas), 8'h02);
    tick(1); check("mc_advance", 8'(filas), 8'h04);
    check("mc_vcount", 8'(vcount), 8'd2);

    // Press on row 2 column 2, then a second key while held.
    columnas = 4'b0100;
    tick(11); check("sk_pre_valid", 8'(key_valid), 8'h00);
    tick(1);
    check("sk_valid", 8'(key_valid), 8'h01);
    check("sk_code", 8'(key_code), 8'h0A);
    columnas = 4'b0110;
    tick(6);
    check("sk_held", 8'(key_held), 8'h01);
    check("sk_frozen", 8'(filas), 8'h04);
    columnas = 4'b0000;
    tick(5); check("sk_rel_early", 8'(key_held), 8'h01);
    tick(1);
    check("sk_rel_held", 8'(key_held), 8'h00);
    check("sk_rel_filas", 8'(filas), 8'h08);
    check("sk_code_kept", 8'(key_code), 8'h0A);
    check("sk_vcount", 8'(vcount), 8'd3);

    // Reset while confirming a press on row 3.
    columnas = 4'b1000;
    tick(9);
    n_reset = 1'b0;
    #1;
    check("rc_filas", 8'(filas), 8'h01);
    check("rc_valid", 8'(key_valid), 8'h00);
    check("rc_held", 8'(key_held), 8'h00);
    check("rc_code", 8'(key_code), 8'h00);
    columnas = 4'b0000;
    tick(2);
    n_reset = 1'b1;
    tick(7); check("rc_row0", 8'(filas), 8'h01);
    tick(1); check("rc_row1", 8'(filas), 8'h02);
    tick(8); check("rc_vcount", 8'(vcount), 8'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
